t06_lcd_bus_receiver: RTL and testbench
=======================================

Name: t06_lcd_bus_receiver

Overview:
- Display-side end of the team's 8080-style 8-bit parallel LCD write bus: the receiver for csx/dcx/wr/D as driven by the image generator.
- Decodes command and parameter bytes (CASET, PASET, RAMWR, SWRESET, SLPOUT, DISPON/DISPOFF) and tracks the column/page address window.
- Assembles RGB565 pixels and emits one (x, y, color) write per pixel toward a frame-memory model or scoreboard.
- Used in simulation and FPGA bring-up in place of the physical panel.

Parameters:
- H_RES, 240, panel columns; legal column addresses 0..H_RES-1.
- V_RES, 320, panel pages (rows); legal page addresses 0..V_RES-1.

Ports:
- clk  in  1  system clock; all bus inputs synchronous to it.
- rst  in  1  synchronous, active-high reset.
- csx  in  1  chip select, active-low.
- dcx  in  1  0 = command byte, 1 = parameter/data byte.
- wr  in  1  write strobe; byte accepted on its rising edge.
- d  in  8  bus data.
- pix_valid  out  1  one-cycle pulse, pixel write.
- pix_x  out  16  pixel column.
- pix_y  out  16  pixel page.
- pix_color  out  16  RGB565, first byte is bits [15:8].
- frame_start  out  1  one-cycle pulse on accepted RAMWR command.
- disp_on  out  1  display-on flag.
- sleep_out  out  1  sleep-out flag.
- cmd_err  out  1  one-cycle pulse on rejected window parameters.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All pulses are 0; pix_x, pix_y and pix_color are 0; disp_on and sleep_out are 0.
  - Window is SC=0, EC=H_RES-1, SP=0, EP=V_RES-1.
  - State is IDLE and wr_q=1.
  - Reset mid-command drops all partial state.
- Edge detect:
  - wr_q registers wr every cycle.
  - Byte strobe = wr & ~wr_q & ~csx, sampled at clock edge k.
  - Every output effect of that byte is visible in cycle k+1; all pulses last exactly one cycle.
  - Back-to-back strobes occur no more often than every 2 clk cycles (one clk high, one low).
- csx high: the state returns to IDLE at the next edge and any partial pixel or parameter bytes are discarded. The window, disp_on and sleep_out are retained.
- States are IDLE, PARAM, PIX_HI and PIX_LO.
- Command byte (dcx=0) is legal in any state. It aborts the current command (partial params discarded, window unchanged) and then decodes:
  - 0x2A CASET or 0x2B PASET: go to PARAM, param count = 0.
  - 0x2C RAMWR: cursor <= (SC, SP), frame_start=1, go to PIX_HI.
  - 0x01 SWRESET: window, disp_on and sleep_out take their reset values; go to IDLE.
  - 0x11 SLPOUT: sleep_out=1. 0x10 SLPIN: sleep_out=0.
  - 0x29 DISPON: disp_on=1. 0x28 DISPOFF: disp_on=0.
  - Any other opcode: go to IDLE; following data bytes are ignored.
- Data byte (dcx=1):
  - IDLE: ignored.
  - PARAM:
    - Shift into a 32-bit register. Byte order is start hi, start lo, end hi, end lo.
    - On the 4th byte, CASET commits if start <= end < H_RES, PASET if start <= end < V_RES. Otherwise the window is unchanged and cmd_err pulses.
    - Then go to IDLE.
    - Bytes beyond the 4th are ignored.
  - PIX_HI: latch the high byte, go to PIX_LO.
  - PIX_LO: pix_valid=1 with pix_x/pix_y = cursor and pix_color = {hi, d}; go to PIX_HI.
    - Cursor advance: col++. If col==EC, col <= SC and page++. If page==EP as well, wrap to (SC, SP).
- pix_x, pix_y and pix_color hold their last values between pulses.
- A simultaneous command and csx rise cannot occur, because the strobe requires csx=0.

Test Plan:
- Reset, then CASET 00 0A 00 0B, PASET 00 14 00 15, RAMWR, then 8 data bytes F8 00 07 E0 00 1F FF FF.
  - frame_start pulses once.
  - 4 pix_valid pulses at (10,20)=F800, (11,20)=07E0, (10,21)=001F, (11,21)=FFFF.
  - Each pulse lands one cycle after the strobe of its low byte.
- Window wrap: same window, 5 pixels.
  - The 5th pixel lands at (10,20).
- Bad params: CASET 00 F0 00 F5 with H_RES=240.
  - cmd_err pulses once on the 4th byte.
  - A following RAMWR starts at the previous SC.
- Abort paths:
  - RAMWR, one data byte AB, then csx high, csx low, data 12 34 → no pix_valid, because the state is IDLE.
  - RAMWR, AB, then command 0x29 → disp_on=1, no pixel.
- Flags:
  - SLPOUT, DISPON → both flags 1.
  - SWRESET → both 0 and window back to 0..239 / 0..319.
  - Unknown 0x36 followed by data 48 → no output change.
- Reset mid-stream: assert rst between the hi and lo bytes of a pixel.
  - All outputs return to reset values.
  - A later lone data byte produces no pixel.

Source files
------------

// File: rtl/t06_lcd_bus_receiver_if.sv
// 8080-style LCD write bus plus the receiver's pixel/status outputs.
// master = image generator side (drives the bus), slave = the receiver.
interface t06_lcd_bus_receiver_if;
    logic        csx;
    logic        dcx;
    logic        wr;
    logic [7:0]  d;
    logic        pix_valid;
    logic [15:0] pix_x;
    logic [15:0] pix_y;
    logic [15:0] pix_color;
    logic        frame_start;
    logic        disp_on;
    logic        sleep_out;
    logic        cmd_err;

    modport master (
        output csx, dcx, wr, d,
        input  pix_valid, pix_x, pix_y, pix_color,
        input  frame_start, disp_on, sleep_out, cmd_err
    );

    modport slave (
        input  csx, dcx, wr, d,
        output pix_valid, pix_x, pix_y, pix_color,
        output frame_start, disp_on, sleep_out, cmd_err
    );
endinterface

// File: rtl/t06_lcd_bus_receiver.sv
// Display-side receiver for the 8-bit 8080 LCD write bus. Decodes the
// window/RAMWR/power commands and turns RGB565 byte pairs into one
// (x, y, color) pixel write each. All outputs are registered, so every
// effect of a byte strobed at edge k is visible during cycle k+1.
module t06_lcd_bus_receiver #(
    parameter int H_RES = 240,
    parameter int V_RES = 320
) (
    input  logic                         clk,
    input  logic                         rst,
    t06_lcd_bus_receiver_if.slave        bus
);

    localparam logic [7:0] OP_SWRESET = 8'h01;
    localparam logic [7:0] OP_SLPIN   = 8'h10;
    localparam logic [7:0] OP_SLPOUT  = 8'h11;
    localparam logic [7:0] OP_DISPOFF = 8'h28;
    localparam logic [7:0] OP_DISPON  = 8'h29;
    localparam logic [7:0] OP_CASET   = 8'h2A;
    localparam logic [7:0] OP_PASET   = 8'h2B;
    localparam logic [7:0] OP_RAMWR   = 8'h2C;

    localparam logic [15:0] COL_MAX = 16'(H_RES - 1);
    localparam logic [15:0] PAGE_MAX = 16'(V_RES - 1);

    typedef enum logic [1:0] {IDLE, PARAM, PIX_HI, PIX_LO} state_t;

    state_t      state_q, state_d;
    logic        wr_q;
    logic [15:0] sc_q, sc_d, ec_q, ec_d, sp_q, sp_d, ep_q, ep_d;
    logic [15:0] col_q, col_d, page_q, page_d;
    logic [7:0]  hi_q, hi_d;
    // Only the first three parameter bytes need storing; the 4th is taken
    // straight off the bus when the window is checked.
    logic [23:0] param_q, param_d;
    logic [1:0]  pcnt_q, pcnt_d;
    logic        is_paset_q, is_paset_d;
    logic        pix_valid_q, pix_valid_d;
    logic [15:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d, pix_color_q, pix_color_d;
    logic        frame_start_q, frame_start_d;
    logic        cmd_err_q, cmd_err_d;
    logic        disp_on_q, disp_on_d;
    logic        sleep_out_q, sleep_out_d;

    logic        strobe;
    logic [31:0] param_full;
    logic [15:0] p_start, p_end;
    logic        p_ok;

    assign strobe     = bus.wr & ~wr_q & ~bus.csx;
    assign param_full = {param_q, bus.d};
    assign p_start    = param_full[31:16];
    assign p_end      = param_full[15:0];
    assign p_ok       = (p_start <= p_end) &&
                        (is_paset_q ? (p_end <= PAGE_MAX) : (p_end <= COL_MAX));

    // Register all state; reset restores the full-panel window and drops partial commands.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_q          <= 1'b1;
            sc_q          <= '0;
            ec_q          <= COL_MAX;
            sp_q          <= '0;
            ep_q          <= PAGE_MAX;
            col_q         <= '0;
            page_q        <= '0;
            hi_q          <= '0;
            param_q       <= '0;
            pcnt_q        <= '0;
            is_paset_q    <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_color_q   <= '0;
            frame_start_q <= 1'b0;
            cmd_err_q     <= 1'b0;
            disp_on_q     <= 1'b0;
            sleep_out_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_q          <= bus.wr;
            sc_q          <= sc_d;
            ec_q          <= ec_d;
            sp_q          <= sp_d;
            ep_q          <= ep_d;
            col_q         <= col_d;
            page_q        <= page_d;
            hi_q          <= hi_d;
            param_q       <= param_d;
            pcnt_q        <= pcnt_d;
            is_paset_q    <= is_paset_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_color_q   <= pix_color_d;
            frame_start_q <= frame_start_d;
            cmd_err_q     <= cmd_err_d;
            disp_on_q     <= disp_on_d;
            sleep_out_q   <= sleep_out_d;
        end
    end

    // Next-state: decode commands and data bytes on each accepted write strobe.
    always_comb begin
        state_d       = state_q;
        sc_d          = sc_q;
        ec_d          = ec_q;
        sp_d          = sp_q;
        ep_d          = ep_q;
        col_d         = col_q;
        page_d        = page_q;
        hi_d          = hi_q;
        param_d       = param_q;
        pcnt_d        = pcnt_q;
        is_paset_d    = is_paset_q;
        pix_valid_d   = 1'b0;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        pix_color_d   = pix_color_q;
        frame_start_d = 1'b0;
        cmd_err_d     = 1'b0;
        disp_on_d     = disp_on_q;
        sleep_out_d   = sleep_out_q;

        if (bus.csx) begin
            // Deselect abandons any partial command; window and flags survive.
            state_d = IDLE;
            pcnt_d  = '0;
        end else if (strobe) begin
            if (!bus.dcx) begin
                // A command always aborts whatever was in progress.
                state_d = IDLE;
                pcnt_d  = '0;
                case (bus.d)
                    OP_CASET: begin
                        state_d    = PARAM;
                        is_paset_d = 1'b0;
                    end
                    OP_PASET: begin
                        state_d    = PARAM;
                        is_paset_d = 1'b1;
                    end
                    OP_RAMWR: begin
                        col_d         = sc_q;
                        page_d        = sp_q;
                        frame_start_d = 1'b1;
                        state_d       = PIX_HI;
                    end
                    OP_SWRESET: begin
                        sc_d        = '0;
                        ec_d        = COL_MAX;
                        sp_d        = '0;
                        ep_d        = PAGE_MAX;
                        disp_on_d   = 1'b0;
                        sleep_out_d = 1'b0;
                    end
                    OP_SLPOUT:  sleep_out_d = 1'b1;
                    OP_SLPIN:   sleep_out_d = 1'b0;
                    OP_DISPON:  disp_on_d   = 1'b1;
                    OP_DISPOFF: disp_on_d   = 1'b0;
                    default: ;
                endcase
            end else begin
                case (state_q)
                    PARAM: begin
                        param_d = param_full[23:0];
                        pcnt_d  = pcnt_q + 2'd1;
                        if (pcnt_q == 2'd3) begin
                            // 4th byte: commit a legal window, otherwise flag it.
                            state_d = IDLE;
                            pcnt_d  = '0;
                            if (!p_ok) begin
                                cmd_err_d = 1'b1;
                            end else if (is_paset_q) begin
                                sp_d = p_start;
                                ep_d = p_end;
                            end else begin
                                sc_d = p_start;
                                ec_d = p_end;
                            end
                        end
                    end
                    PIX_HI: begin
                        hi_d    = bus.d;
                        state_d = PIX_LO;
                    end
                    PIX_LO: begin
                        pix_valid_d = 1'b1;
                        pix_x_d     = col_q;
                        pix_y_d     = page_q;
                        pix_color_d = {hi_q, bus.d};
                        state_d     = PIX_HI;
                        // Raster advance inside the window, wrapping at the last page.
                        if (col_q == ec_q) begin
                            col_d  = sc_q;
                            page_d = (page_q == ep_q) ? sp_q : page_q + 16'd1;
                        end else begin
                            col_d = col_q + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.pix_valid   = pix_valid_q;
    assign bus.pix_x       = pix_x_q;
    assign bus.pix_y       = pix_y_q;
    assign bus.pix_color   = pix_color_q;
    assign bus.frame_start = frame_start_q;
    assign bus.cmd_err     = cmd_err_q;
    assign bus.disp_on     = disp_on_q;
    assign bus.sleep_out   = sleep_out_q;

endmodule

// File: tb/tb_t06_lcd_bus_receiver.sv
// Bench for t06_lcd_bus_receiver: a table of bus bytes with expected pulses
// and flags, a pixel scoreboard filled as low bytes are driven, and a
// hand-written mid-stream reset sequence.
module tb_t06_lcd_bus_receiver;

    typedef struct {
        logic        op_cs;   // 1 = deselect pulse instead of a byte
        logic        dcx;
        logic [7:0]  d;
        logic        pix;
        logic [15:0] x, y, color;
        logic        fs, err, don, slp;
    } vec_t;

    typedef struct {
        logic [15:0] x, y, color;
    } pix_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    t06_lcd_bus_receiver_if bus();

    t06_lcd_bus_receiver #(.H_RES(240), .V_RES(320)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    vec_t vq[$];
    pix_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   row = 0;
    logic e_don = 1'b0, e_slp = 1'b0;
    logic [15:0] last_x = '0, last_y = '0, last_c = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h want %0h", name, row, act, exp);
        end
    endtask

    task automatic b(input logic dc, input logic [7:0] dd, input logic fs = 1'b0,
                     input logic er = 1'b0);
        vec_t v;
        v = '{default: '0};
        v.dcx = dc; v.d = dd; v.fs = fs; v.err = er; v.don = e_don; v.slp = e_slp;
        vq.push_back(v);
    endtask

    task automatic px(input logic [15:0] c, input int x, input int y);
        vec_t v;
        b(1'b1, c[15:8]);
        v = '{default: '0};
        v.dcx = 1'b1; v.d = c[7:0]; v.pix = 1'b1;
        v.x = 16'(x); v.y = 16'(y); v.color = c; v.don = e_don; v.slp = e_slp;
        vq.push_back(v);
    endtask

    task automatic cshi();
        vec_t v;
        v = '{default: '0};
        v.op_cs = 1'b1; v.don = e_don; v.slp = e_slp;
        vq.push_back(v);
    endtask

    // Pulses from the previous strobe must be gone, and pixel outputs held.
    task automatic chk_quiet();
        chk("pulse_clear", {29'd0, bus.pix_valid, bus.frame_start, bus.cmd_err}, 32'd0);
        chk("hold_xyc", {bus.pix_x, bus.pix_color}, {last_x, last_c});
        chk("hold_y", {16'd0, bus.pix_y}, {16'd0, last_y});
    endtask

    task automatic run_vec(input vec_t v);
        pix_t e;
        if (v.op_cs) begin
            @(negedge clk); bus.csx = 1'b1; bus.wr = 1'b1;
            @(posedge clk); #1;
            chk_quiet();
            @(negedge clk); bus.csx = 1'b0;
            @(posedge clk); #1;
            chk("cs_don", {31'd0, bus.disp_on}, {31'd0, v.don});
            chk("cs_slp", {31'd0, bus.sleep_out}, {31'd0, v.slp});
        end else begin
            @(negedge clk);
            bus.csx = 1'b0; bus.dcx = v.dcx; bus.d = v.d; bus.wr = 1'b0;
            if (v.pix) sb_q.push_back('{x: v.x, y: v.y, color: v.color});
            @(posedge clk); #1;
            chk_quiet();
            @(negedge clk); bus.wr = 1'b1;
            @(posedge clk); #1;
            chk("pix_valid", {31'd0, bus.pix_valid}, {31'd0, v.pix});
            chk("frame_start", {31'd0, bus.frame_start}, {31'd0, v.fs});
            chk("cmd_err", {31'd0, bus.cmd_err}, {31'd0, v.err});
            chk("disp_on", {31'd0, bus.disp_on}, {31'd0, v.don});
            chk("sleep_out", {31'd0, bus.sleep_out}, {31'd0, v.slp});
            if (bus.pix_valid) begin
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pixel row %0d: got (%0d,%0d)=%0h want none",
                             row, bus.pix_x, bus.pix_y, bus.pix_color);
                end else begin
                    e = sb_q.pop_front();
                    chk("pix_x", {16'd0, bus.pix_x}, {16'd0, e.x});
                    chk("pix_y", {16'd0, bus.pix_y}, {16'd0, e.y});
                    chk("pix_color", {16'd0, bus.pix_color}, {16'd0, e.color});
                    last_x = e.x; last_y = e.y; last_c = e.color;
                end
            end else if (v.pix && sb_q.size() != 0) begin
                void'(sb_q.pop_back());
            end
        end
        row++;
    endtask

    task automatic flush();
        while (vq.size() != 0) run_vec(vq.pop_front());
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pulses"}, {29'd0, bus.pix_valid, bus.frame_start, bus.cmd_err}, 32'd0);
        chk({tag, "_xy"}, {bus.pix_x, bus.pix_y}, 32'd0);
        chk({tag, "_color"}, {16'd0, bus.pix_color}, 32'd0);
        chk({tag, "_flags"}, {30'd0, bus.disp_on, bus.sleep_out}, 32'd0);
    endtask

    initial begin
        bus.csx = 1'b1; bus.dcx = 1'b1; bus.wr = 1'b1; bus.d = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk); rst = 1'b0;

        // Basic window + 4 pixels
        b(0, 8'h2A); b(1, 8'h00); b(1, 8'h0A); b(1, 8'h00); b(1, 8'h0B);
        b(0, 8'h2B); b(1, 8'h00); b(1, 8'h14); b(1, 8'h00); b(1, 8'h15);
        b(0, 8'h2C, 1'b1);
        px(16'hF800, 10, 20); px(16'h07E0, 11, 20); px(16'h001F, 10, 21); px(16'hFFFF, 11, 21);
        // Window wrap back to (SC,SP)
        b(0, 8'h2C, 1'b1);
        px(16'h1111, 10, 20); px(16'h2222, 11, 20); px(16'h3333, 10, 21);
        px(16'h4444, 11, 21); px(16'h5555, 10, 20);
        // Command mid-CASET drops the partial parameters
        b(0, 8'h2A); b(1, 8'h00); b(1, 8'h05);
        b(0, 8'h2C, 1'b1); px(16'h6666, 10, 20);
        // Rejected windows: end past H_RES, start > end, page end == V_RES
        b(0, 8'h2A); b(1, 8'h00); b(1, 8'hF0); b(1, 8'h00); b(1, 8'hF5, 1'b0, 1'b1);
        b(1, 8'h77);
        b(0, 8'h2A); b(1, 8'h00); b(1, 8'h0B); b(1, 8'h00); b(1, 8'h0A, 1'b0, 1'b1);
        b(0, 8'h2B); b(1, 8'h00); b(1, 8'h00); b(1, 8'h01); b(1, 8'h40, 1'b0, 1'b1);
        b(0, 8'h2C, 1'b1); px(16'hABCD, 10, 20);
        // Abort via deselect
        b(0, 8'h2C, 1'b1); b(1, 8'hAB); cshi(); b(1, 8'h12); b(1, 8'h34);
        // Abort via command
        b(0, 8'h2C, 1'b1); b(1, 8'hAB); e_don = 1'b1; b(0, 8'h29); b(1, 8'hCD);
        // Flags
        e_slp = 1'b1; b(0, 8'h11); b(0, 8'h29);
        e_don = 1'b0; e_slp = 1'b0; b(0, 8'h01);
        b(0, 8'h36); b(1, 8'h48);
        e_don = 1'b1; b(0, 8'h29); e_don = 1'b0; b(0, 8'h28);
        e_slp = 1'b1; b(0, 8'h11); e_slp = 0; b(0, 8'h10);
        // Largest legal windows are accepted
        b(0, 8'h2A); b(1, 8'h00); b(1, 8'h00); b(1, 8'h00); b(1, 8'hEF);
        b(0, 8'h2B); b(1, 8'h00); b(1, 8'h00); b(1, 8'h01); b(1, 8'h3F);
        // Full-width row after SWRESET: column 239 then wrap to (0,1)
        b(0, 8'h2C, 1'b1);
        for (int i = 0; i < 241; i++) px(16'(i * 3 + 1), i % 240, i / 240);
        flush();

        // Reset between the hi and lo bytes of a pixel
        b(0, 8'h2A); b(1, 8'h00); b(1, 8'h05); b(1, 8'h00); b(1, 8'h06);
        e_slp = 1'b1; b(0, 8'h11); e_don = 1'b1; b(0, 8'h29);
        b(0, 8'h2C, 1'b1); b(1, 8'h55);
        flush();
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals("midrst");
        @(negedge clk); rst = 1'b0;
        last_x = '0; last_y = '0; last_c = '0;
        e_don = 1'b0; e_slp = 1'b0;
        b(1, 8'h66);
        b(0, 8'h2C, 1'b1); px(16'h1234, 0, 0); px(16'h5678, 1, 0);
        flush();

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute bound so a stuck run still ends with a report.
    initial begin
        #2000000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
